// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter.
// State encoding and port index constants.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ADDR   = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  localparam logic ARB_PORT_CPU = 1'b0;
  localparam logic ARB_PORT_DBG = 1'b1;

endpackage

// File: rtl/arb_rr_select.sv
// Two-way round-robin pick: req[1:0], rr_last in; one-hot pick out.
// On a tie the port that was not served last wins.
module arb_rr_select
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (req[ARB_PORT_CPU] && req[ARB_PORT_DBG]) begin
      if (rr_last == ARB_PORT_DBG) pick[ARB_PORT_CPU] = 1'b1;
      else                         pick[ARB_PORT_DBG] = 1'b1;
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one 8-bit memory port between CPU (0) and debug (1) requesters.
// Ports: req/lock/we/addr/wdata per port in; gnt/done/rdata, mem_* out.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_en,
  input  logic [7:0]        mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  arb_state_t  state;
  logic [CW-1:0] cnt;
  logic        rr_last;
  logic [1:0]  pick;

  logic              sel_dbg;
  logic [ADDR_W-1:0] nxt_addr;
  logic [7:0]        nxt_wdata;
  logic              nxt_we;
  logic              own_req;
  logic              own_lock;

  arb_rr_select u_sel (
    .req     (req),
    .rr_last (rr_last),
    .pick    (pick)
  );

  // In DONE the relatch source is the current owner, otherwise the winner.
  always_comb begin
    sel_dbg   = (state == ARB_DONE) ? gnt[ARB_PORT_DBG]
                                    : pick[ARB_PORT_DBG];
    nxt_addr  = sel_dbg ? addr1  : addr0;
    nxt_wdata = sel_dbg ? wdata1 : wdata0;
    nxt_we    = we[sel_dbg];
    own_req   = req[gnt[ARB_PORT_DBG]];
    own_lock  = lock[gnt[ARB_PORT_DBG]];
  end

  // mem_addr/mem_wdata/mem_we double as the request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      rr_last   <= ARB_PORT_DBG;
      gnt       <= 2'b00;
      done      <= 2'b00;
      rdata     <= 8'h00;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_en    <= 1'b0;
    end else begin
      done <= 2'b00;
      unique case (state)
        ARB_IDLE: begin
          if (|pick) begin
            gnt       <= pick;
            mem_addr  <= nxt_addr;
            mem_wdata <= nxt_wdata;
            mem_we    <= nxt_we;
            state     <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          cnt    <= CNT_LOAD;
          mem_en <= 1'b1;
          state  <= ARB_ACCESS;
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            if (!mem_we) rdata <= mem_rdata;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            done    <= gnt;
            rr_last <= gnt[ARB_PORT_DBG];
            state   <= ARB_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_DONE: begin
          if (own_lock && own_req) begin
            mem_addr  <= nxt_addr;
            mem_wdata <= nxt_wdata;
            mem_we    <= nxt_we;
            state     <= ARB_ADDR;
          end else begin
            gnt   <= 2'b00;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter (MEM_LAT=2 and MEM_LAT=1 builds).
// Expected done port / read data queued at issue, checked at done.
module tb_mem_bus_arbiter;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  lock = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [15:0] addr0 = '0;
  logic [15:0] addr1 = '0;
  logic [7:0]  wdata0 = '0;
  logic [7:0]  wdata1 = '0;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_en;
  logic [7:0]  mem_rdata;

  logic [1:0]  req1 = 2'b00;
  logic [15:0] addr0_1 = '0;
  logic [1:0]  gnt1;
  logic [1:0]  done1;
  logic [7:0]  rdata1;
  logic [15:0] mem_addr1;
  logic [7:0]  mem_wdata1;
  logic        mem_we1;
  logic        mem_en1;
  logic [7:0]  mem_rdata1;

  logic [7:0] mem [256];
  exp_t       sb[$];
  int         dq[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         ndone = 0;
  int         done_cyc = 0;
  int         en_cnt = 0;
  int         cpu_gnt_cyc = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
    .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .lock(2'b00), .we(2'b00),
    .addr0(addr0_1), .addr1(16'h0000), .wdata0(8'h00), .wdata1(8'h00),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_en(mem_en1),
    .mem_rdata(mem_rdata1)
  );

  function automatic logic [7:0] rd_val(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (lo == 8'h10) ? 8'hA5 : (lo ^ 8'h5A);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16] = 8'hA5;
  end

  always @(posedge clk)
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  assign mem_rdata  = (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 8'hEE;
  assign mem_rdata1 = mem_en1 ? (mem_addr1[7:0] ^ 8'hC3) : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (mem_en) en_cnt++;
    if (gnt == 2'b01) cpu_gnt_cyc++;
    if (done != 2'b00) begin
      done_cyc = cyc;
      dq.push_back(cyc);
      ndone++;
      if (sb.size() == 0) begin
        check("sb_underflow", {30'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_port", {30'd0, done},
              e.port ? 32'd2 : 32'd1);
        check("gnt_at_done", {30'd0, gnt}, {30'd0, done});
        if (!e.we) check("rdata", {24'd0, rdata}, {24'd0, e.data});
      end
    end
  end

  task automatic push(input logic p, input logic w,
                      input logic [7:0] d);
    exp_t e;
    e.port = p;
    e.we   = w;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int n, input int lim);
    int k = 0;
    while (ndone < n && k < lim) begin
      @(negedge clk); #1;
      k++;
    end
    check("wait_done", {31'd0, ndone >= n}, 32'd1);
  endtask

  task automatic wait_gnt(input logic [1:0] g, input int lim);
    int k = 0;
    while (gnt != g && k < lim) begin
      @(negedge clk); #1;
      k++;
    end
    check("wait_gnt", {30'd0, gnt}, {30'd0, g});
  endtask

  task automatic wait_en(input int lim);
    int k = 0;
    while (!mem_en && k < lim) begin
      @(negedge clk); #1;
      k++;
    end
    check("wait_en", {31'd0, mem_en}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    req = 2'b00; lock = 2'b00; req1 = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    int c;
    int nd0;
    int en1;
    int k;

    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_en", {31'd0, mem_en}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b0;

    // single CPU read
    addr0 = 16'h0010; we = 2'b00; req = 2'b01;
    push(1'b0, 1'b0, 8'hA5);
    c = cyc; en_cnt = 0;
    wait_done(1, 20);
    req = 2'b00;
    check("rd_lat", done_cyc - c, 32'd4);
    check("rd_en_cyc", en_cnt, 32'd2);
    check("rd_data", {24'd0, rdata}, 32'hA5);

    // tie from reset: CPU, DBG, CPU, DBG
    do_reset();
    addr0 = 16'h0020; addr1 = 16'h0030; we = 2'b00;
    push(1'b0, 1'b0, rd_val(16'h0020));
    push(1'b1, 1'b0, rd_val(16'h0030));
    push(1'b0, 1'b0, rd_val(16'h0020));
    push(1'b1, 1'b0, rd_val(16'h0030));
    nd0 = ndone;
    req = 2'b11;
    wait_done(nd0 + 4, 60);
    req = 2'b00;
    check("tie_sb_empty", sb.size(), 32'd0);

    // DBG locked write burst with CPU waiting
    @(negedge clk); #1;
    nd0 = ndone;
    dq.delete();
    addr1 = 16'h0100; wdata1 = 8'h11; we = 2'b10; lock = 2'b10;
    addr0 = 16'h0040;
    req = 2'b10;
    push(1'b1, 1'b1, 8'h00);
    push(1'b1, 1'b1, 8'h00);
    push(1'b1, 1'b1, 8'h00);
    push(1'b0, 1'b0, rd_val(16'h0040));
    wait_gnt(2'b10, 10);
    cpu_gnt_cyc = 0;
    req = 2'b11;
    wait_done(nd0 + 1, 20);
    addr1 = 16'h0101; wdata1 = 8'h22;
    wait_done(nd0 + 2, 20);
    addr1 = 16'h0102; wdata1 = 8'h33;
    wait_done(nd0 + 3, 20);
    lock = 2'b00; req = 2'b01;
    check("lock_no_cpu", cpu_gnt_cyc, 32'd0);
    check("lock_gap1", dq[1] - dq[0], 32'd4);
    check("lock_gap2", dq[2] - dq[1], 32'd4);
    check("wr_0100", {24'd0, mem[8'h00]}, 32'h11);
    check("wr_0101", {24'd0, mem[8'h01]}, 32'h22);
    check("wr_0102", {24'd0, mem[8'h02]}, 32'h33);
    wait_done(nd0 + 4, 20);
    req = 2'b00;

    // CPU drops req mid-access
    @(negedge clk); #1;
    nd0 = ndone;
    addr0 = 16'h0050; we = 2'b00; req = 2'b01;
    push(1'b0, 1'b0, rd_val(16'h0050));
    en_cnt = 0;
    wait_en(10);
    req = 2'b00;
    wait_done(nd0 + 1, 20);
    check("drop_en_cyc", en_cnt, 32'd2);
    @(negedge clk); #1;
    check("drop_idle_gnt", {30'd0, gnt}, 32'd0);
    check("drop_idle_en", {31'd0, mem_en}, 32'd0);

    // reset during ACCESS
    addr0 = 16'h0060; req = 2'b01;
    push(1'b0, 1'b0, rd_val(16'h0060));
    wait_en(10);
    reset = 1'b1; req = 2'b00;
    @(negedge clk); #1;
    sb.delete();
    check("mid_rst_en", {31'd0, mem_en}, 32'd0);
    check("mid_rst_gnt", {30'd0, gnt}, 32'd0);
    check("mid_rst_done", {30'd0, done}, 32'd0);
    check("mid_rst_rdata", {24'd0, rdata}, 32'd0);
    reset = 1'b0;
    nd0 = ndone;
    repeat (3) @(negedge clk);
    #1;
    check("mid_rst_nodone", ndone, nd0);
    addr0 = 16'h0070; req = 2'b01;
    push(1'b0, 1'b0, rd_val(16'h0070));
    c = cyc;
    wait_done(nd0 + 1, 20);
    req = 2'b00;
    check("post_rst_lat", done_cyc - c, 32'd4);

    // MEM_LAT=1 build
    @(negedge clk); #1;
    addr0_1 = 16'h0077; req1 = 2'b01;
    c = cyc; en1 = 0; k = 0;
    while (done1 == 2'b00 && k < 20) begin
      @(negedge clk); #1;
      if (mem_en1) en1++;
      k++;
    end
    check("l1_done", {30'd0, done1}, 32'd1);
    check("l1_lat", cyc - c, 32'd3);
    check("l1_en_cyc", en1, 32'd1);
    check("l1_rdata", {24'd0, rdata1}, {24'd0, 8'h77 ^ 8'hC3});
    req1 = 2'b00;

    repeat (3) @(negedge clk);
    check("sb_final_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
